uart_parity_engine: RTL and testbench

Parametrised parity generator/checker for the UART datapath, replacing the fixed 8-bit even-parity block. It computes parity over a configurable-length frame either in one shot from a parallel word (TX side) or bit-by-bit as the shifter strobes bits (RX side). It supports even/odd/mark/space/none modes and checks a received parity bit against the computed value. It sits between the UART shift registers and the frame-control FSMs.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_parity_engine_if.sv | 47 ++++
 rtl/uart_parity_engine_parity_reduce.sv | 16 +
 rtl/uart_parity_engine.sv | 165 ++++++++++++++++
 tb/tb_uart_parity_engine.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, parity-engine FSM states and width limits.
package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_READY = 2'd2
  } par_state_t;

  localparam int MIN_DATA_W = 5;

  // Encodings 5..7 are reserved and fold onto PAR_NONE.
  function automatic parity_mode_t decode_mode(logic [2:0] m);
    case (m)
      3'd1:    return PAR_EVEN;
      3'd2:    return PAR_ODD;
      3'd3:    return PAR_MARK;
      3'd4:    return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_parity_engine_if.sv
// Handshake bundle between the UART shifters/frame FSMs and the parity engine.
// PARITY_ERR_CNT_EN adds the err_count/err_clr pair.
interface uart_parity_engine_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
`ifdef PARITY_ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic [2:0]        mode;
  logic [LEN_W-1:0]  frame_len;
  logic              par_load;
  logic [DATA_W-1:0] par_data;
  logic              ser_start;
  logic              ser_bit_valid;
  logic              ser_bit;
  logic              chk_valid;
  logic              chk_bit;
  logic              busy;
  logic              parity_valid;
  logic              parity_bit;
  logic              parity_err;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0]  err_count;
  logic              err_clr;
`endif

  modport master (
`ifdef PARITY_ERR_CNT_EN
    input  err_count,
    output err_clr,
`endif
    output mode, frame_len, par_load, par_data, ser_start, ser_bit_valid,
    output ser_bit, chk_valid, chk_bit,
    input  busy, parity_valid, parity_bit, parity_err
  );

  modport slave (
`ifdef PARITY_ERR_CNT_EN
    output err_count,
    input  err_clr,
`endif
    input  mode, frame_len, par_load, par_data, ser_start, ser_bit_valid,
    input  ser_bit, chk_valid, chk_bit,
    output busy, parity_valid, parity_bit, parity_err
  );
endinterface

// File: rtl/uart_parity_engine_parity_reduce.sv
// Masked XOR reduction: parity of data[len-1:0]. Shared with the RX checker path.
module parity_reduce #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic [DATA_W-1:0] data,
  input  logic [LEN_W-1:0]  len,
  output logic              parity
);
  always_comb begin
    parity = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (LEN_W'(i) < len) parity = parity ^ data[i];
    end
  end
endmodule

// File: rtl/uart_parity_engine.sv
// Parity generator/checker: one-shot parallel or bit-serial accumulation, then check.
// Optional feature macro: PARITY_ERR_CNT_EN (saturating mismatch counter with clear).
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
`ifdef PARITY_ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_parity_engine_if.slave   bus
);

  if (DATA_W < MIN_DATA_W || DATA_W > 16) begin : g_bad_data_w
    $error("uart_parity_engine: DATA_W must be 5..16");
  end
  if ((1 << LEN_W) <= DATA_W) begin : g_bad_len_w
    $error("uart_parity_engine: LEN_W too narrow for DATA_W");
  end

  function automatic logic apply_mode(parity_mode_t m, logic raw);
    case (m)
      PAR_EVEN: return raw;
      PAR_ODD:  return ~raw;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  par_state_t   state_q, state_d;
  parity_mode_t mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic acc_q, acc_d;
  logic busy_q, busy_d;
  logic pvalid_q, pvalid_d;
  logic pbit_q, pbit_d;
  logic perr_q, perr_d;

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] cnt_inc;
  logic             par_raw;
  parity_mode_t     mode_in;
  logic             can_start;

  // Out-of-range lengths (0 or wider than the datapath) mean a full-width frame.
  assign eff_len   = (bus.frame_len == '0 || bus.frame_len > LEN_W'(DATA_W))
                     ? LEN_W'(DATA_W) : bus.frame_len;
  assign mode_in   = decode_mode(bus.mode);
  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign can_start = (state_q != ST_ACCUM);

  parity_reduce #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_reduce (
    .data   (bus.par_data),
    .len    (eff_len),
    .parity (par_raw)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    pbit_d   = pbit_q;
    pvalid_d = 1'b0;
    perr_d   = 1'b0;

    if (can_start && bus.par_load) begin
      mode_d   = mode_in;
      len_d    = eff_len;
      cnt_d    = '0;
      acc_d    = 1'b0;
      pbit_d   = apply_mode(mode_in, par_raw);
      pvalid_d = 1'b1;
      state_d  = ST_READY;
    end else if (can_start && bus.ser_start) begin
      // A strobe coincident with ser_start is the first bit of the new frame.
      mode_d  = mode_in;
      len_d   = eff_len;
      acc_d   = bus.ser_bit_valid & bus.ser_bit;
      cnt_d   = bus.ser_bit_valid ? LEN_W'(1) : '0;
      state_d = ST_ACCUM;
      if (bus.ser_bit_valid && eff_len == LEN_W'(1)) begin
        pbit_d   = apply_mode(mode_in, bus.ser_bit);
        pvalid_d = 1'b1;
        state_d  = ST_READY;
      end
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (bus.ser_bit_valid) begin
            acc_d = acc_q ^ bus.ser_bit;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              pbit_d   = apply_mode(mode_q, acc_q ^ bus.ser_bit);
              pvalid_d = 1'b1;
              state_d  = ST_READY;
            end
          end
        end
        ST_READY: begin
          if (bus.chk_valid) begin
            perr_d  = (bus.chk_bit != pbit_q) && (mode_q != PAR_NONE);
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= PAR_NONE;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      busy_q   <= 1'b0;
      pvalid_q <= 1'b0;
      pbit_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      pvalid_q <= pvalid_d;
      pbit_q   <= pbit_d;
      perr_q   <= perr_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.parity_valid = pvalid_q;
  assign bus.parity_bit   = pbit_q;
  assign bus.parity_err   = perr_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Counts alongside the registered pulse; a clear in the same cycle wins.
  always_comb begin
    err_count_d = err_count_q;
    if (bus.err_clr)                           err_count_d = '0;
    else if (perr_d && err_count_q != '1)      err_count_d = err_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Randomised + directed bench for uart_parity_engine against a queue-based frame model.
module tb_uart_parity_engine;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 5;
`ifdef PARITY_ERR_CNT_EN
  localparam int CNT_W  = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef PARITY_ERR_CNT_EN
  uart_parity_engine_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus();
  uart_parity_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`else
  uart_parity_engine_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus();
  uart_parity_engine #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference: collected serial bits, whether a result awaits a check.
  bit   m_collecting;
  bit   m_have;
  bit   m_bits[$];
  int   m_len;
  int   m_mode;
  logic m_par, m_pv, m_err, m_busy;
  int   m_cnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic final_par(int md, int ones);
    case (md)
      1:       return logic'(ones % 2 == 1);
      2:       return logic'(ones % 2 == 0);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic finish_if_full();
    int ones;
    if (m_bits.size() == m_len) begin
      ones = 0;
      foreach (m_bits[i]) ones += int'(m_bits[i]);
      m_par = final_par(m_mode, ones);
      m_pv = 1'b1;
      m_collecting = 1'b0;
      m_have = 1'b1;
    end
  endtask

  task automatic model_update();
    int fl, el;
    logic [DATA_W-1:0] mask;
    m_pv = 1'b0;
    m_err = 1'b0;
    fl = int'(bus.frame_len);
    el = (fl == 0 || fl > DATA_W) ? DATA_W : fl;
    if (rst) begin
      m_collecting = 1'b0;
      m_have = 1'b0;
      m_par = 1'b0;
      m_bits.delete();
      m_cnt = 0;
    end else begin
      if (!m_collecting && bus.par_load) begin
        m_mode = int'(bus.mode);
        m_len = el;
        mask = DATA_W'((1 << el) - 1);
        m_par = final_par(m_mode, $countones(bus.par_data & mask));
        m_pv = 1'b1;
        m_have = 1'b1;
      end else if (!m_collecting && bus.ser_start) begin
        m_mode = int'(bus.mode);
        m_len = el;
        m_bits.delete();
        m_have = 1'b0;
        m_collecting = 1'b1;
        if (bus.ser_bit_valid) begin
          m_bits.push_back(bus.ser_bit);
          finish_if_full();
        end
      end else if (m_collecting && bus.ser_bit_valid) begin
        m_bits.push_back(bus.ser_bit);
        finish_if_full();
      end else if (m_have && bus.chk_valid) begin
        m_err = (bus.chk_bit != m_par) && (m_mode >= 1 && m_mode <= 4);
        m_have = 1'b0;
      end
`ifdef PARITY_ERR_CNT_EN
      if (bus.err_clr) m_cnt = 0;
      else if (m_err && m_cnt != (1 << CNT_W) - 1) m_cnt++;
`endif
    end
    m_busy = m_collecting;
  endtask

  // One clock: update the model from the applied inputs, then compare outputs after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("busy",         32'(bus.busy),         32'(m_busy));
    chk("parity_valid", 32'(bus.parity_valid), 32'(m_pv));
    chk("parity_err",   32'(bus.parity_err),   32'(m_err));
    if (m_pv) chk("parity_bit", 32'(bus.parity_bit), 32'(m_par));
`ifdef PARITY_ERR_CNT_EN
    chk("err_count", 32'(bus.err_count), 32'(m_cnt));
`endif
  endtask

  task automatic clear_strobes();
    bus.par_load = 1'b0;
    bus.ser_start = 1'b0;
    bus.ser_bit_valid = 1'b0;
    bus.ser_bit = 1'b0;
    bus.chk_valid = 1'b0;
    bus.chk_bit = 1'b0;
`ifdef PARITY_ERR_CNT_EN
    bus.err_clr = 1'b0;
`endif
  endtask

  task automatic par_frame(int md, int len, logic [DATA_W-1:0] d);
    bus.mode = 3'(md);
    bus.frame_len = LEN_W'(len);
    bus.par_data = d;
    bus.par_load = 1'b1;
    step();
    clear_strobes();
  endtask

  task automatic send_bit(logic b);
    bus.ser_bit_valid = 1'b1;
    bus.ser_bit = b;
    step();
    clear_strobes();
  endtask

  initial begin
    logic [6:0] sbits;
    clear_strobes();
    bus.mode = 3'd0;
    bus.frame_len = '0;
    bus.par_data = '0;
    m_cnt = 0;
    rst = 1'b1;
    step();
    step();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_pvalid", 32'(bus.parity_valid), 32'd0);
    chk("reset_pbit", 32'(bus.parity_bit), 32'd0);
    chk("reset_perr", 32'(bus.parity_err), 32'd0);
    rst = 1'b0;
    step();

    // Parallel even, B5 has five ones.
    par_frame(1, 8, 8'hB5);
    chk("par_even_valid", 32'(bus.parity_valid), 32'd1);
    chk("par_even_bit", 32'(bus.parity_bit), 32'd1);
    chk("model_par_even", 32'(m_par), 32'd1);
    step();

    // Parallel odd over the low five bits of FF.
    par_frame(2, 5, 8'hFF);
    chk("par_odd_bit", 32'(bus.parity_bit), 32'd0);
    chk("model_par_odd", 32'(m_par), 32'd0);

    // Serial even, 7 bits with gaps.
    bus.mode = 3'd1;
    bus.frame_len = LEN_W'(7);
    bus.ser_start = 1'b1;
    step();
    clear_strobes();
    chk("ser_busy_rise", 32'(bus.busy), 32'd1);
    sbits = 7'b0001101;
    for (int i = 0; i < 7; i++) begin
      send_bit(sbits[i]);
      if (i < 6) begin
        chk("ser_busy_hold", 32'(bus.busy), 32'd1);
        step();
      end
    end
    chk("ser_done_valid", 32'(bus.parity_valid), 32'd1);
    chk("ser_done_bit", 32'(bus.parity_bit), 32'd1);
    chk("ser_done_busy", 32'(bus.busy), 32'd0);
    chk("model_ser", 32'(m_par), 32'd1);

    // Mismatch check, then the same in mode none.
    bus.chk_valid = 1'b1;
    bus.chk_bit = 1'b0;
    step();
    clear_strobes();
    chk("chk_err_pulse", 32'(bus.parity_err), 32'd1);
    step();
    chk("chk_err_drop", 32'(bus.parity_err), 32'd0);
    par_frame(0, 8, 8'h01);
    bus.chk_valid = 1'b1;
    bus.chk_bit = 1'b1;
    step();
    clear_strobes();
    chk("chk_none_noerr", 32'(bus.parity_err), 32'd0);

    // par_load and ser_start together: parallel wins.
    bus.ser_start = 1'b1;
    par_frame(1, 8, 8'h07);
    chk("both_par_valid", 32'(bus.parity_valid), 32'd1);
    chk("both_par_busy", 32'(bus.busy), 32'd0);
    chk("both_par_bit", 32'(bus.parity_bit), 32'd1);

    // par_load during ACCUM ignored, then reset mid-frame.
    bus.mode = 3'd1;
    bus.frame_len = LEN_W'(8);
    bus.ser_start = 1'b1;
    step();
    clear_strobes();
    par_frame(1, 8, 8'hFE);
    chk("accum_par_ignored", 32'(bus.parity_valid), 32'd0);
    chk("accum_still_busy", 32'(bus.busy), 32'd1);
    send_bit(1'b1);
    rst = 1'b1;
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pbit", 32'(bus.parity_bit), 32'd0);
    chk("rst_pvalid", 32'(bus.parity_valid), 32'd0);
    rst = 1'b0;
    step();

`ifdef PARITY_ERR_CNT_EN
    for (int k = 0; k < 5; k++) begin
      par_frame(1, 8, 8'h01);
      bus.chk_valid = 1'b1;
      bus.chk_bit = 1'b0;
      step();
      clear_strobes();
    end
    chk("cnt_saturated", 32'(bus.err_count), 32'd3);
    par_frame(1, 8, 8'h01);
    bus.chk_valid = 1'b1;
    bus.chk_bit = 1'b0;
    bus.err_clr = 1'b1;
    step();
    clear_strobes();
    chk("cnt_clr_wins", 32'(bus.err_count), 32'd0);
`endif

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.mode = 3'($urandom_range(0, 7));
      bus.frame_len = LEN_W'($urandom_range(0, 31));
      bus.par_data = DATA_W'($urandom);
      bus.par_load = ($urandom_range(0, 19) == 0);
      bus.ser_start = ($urandom_range(0, 14) == 0);
      bus.ser_bit_valid = ($urandom_range(0, 1) == 1);
      bus.ser_bit = 1'($urandom);
      bus.chk_valid = ($urandom_range(0, 3) == 0);
      bus.chk_bit = 1'($urandom);
`ifdef PARITY_ERR_CNT_EN
      bus.err_clr = ($urandom_range(0, 29) == 0);
`endif
      step();
    end
    rst = 1'b0;
    clear_strobes();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
